// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared types and helpers for the Viterbi frame sequencer.
// Holds the controller state encoding, default sizes and a popcount helper.
package viterbi_ctrl_pkg;

    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_TAIL_LEN  = 2;
    localparam int DEF_DEC_LAT   = 12;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TAIL,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Frames up to 32 bits; callers zero-extend their operand.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Host-side handshake bundle of the frame sequencer.
// master: host driver (start_i/frame_i/abort_i); slave: the controller.
interface viterbi_frame_ctrl_if #(
    parameter int FRAME_LEN = 8
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    logic                 start_i;
    logic [FRAME_LEN-1:0] frame_i;
    logic                 abort_i;
    logic                 ready_o;
    logic                 done_o;
    logic [FRAME_LEN-1:0] rx_word_o;
    logic [CNT_W-1:0]     err_cnt_o;

    modport master (
        output start_i, frame_i, abort_i,
        input  ready_o, done_o, rx_word_o, err_cnt_o
    );

    modport slave (
        input  start_i, frame_i, abort_i,
        output ready_o, done_o, rx_word_o, err_cnt_o
    );

endinterface

// File: rtl/viterbi_stat_counter.sv
// Frame statistics: wrapping frame counter, saturating error total.
// Ports: clk, rst (async active-low), inc_i, add_i, frames_o, err_total_o.
module viterbi_stat_counter #(
    parameter int STAT_W = 16,
    parameter int ADD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic [ADD_W-1:0]  add_i,
    output logic [STAT_W-1:0] frames_o,
    output logic [STAT_W-1:0] err_total_o
);

    logic [STAT_W:0] sum;

    // One extra bit catches the overflow that triggers saturation.
    assign sum = {1'b0, err_total_o} + (STAT_W + 1)'(add_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_o    <= '0;
            err_total_o <= '0;
        end else if (inc_i) begin
            frames_o    <= frames_o + 1'b1;
            err_total_o <= sum[STAT_W] ? '1 : sum[STAT_W-1:0];
        end
    end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: serialises a word into the encoder, flushes the trellis,
// captures the decoder output and reports word, error count and statistics.
// Ports: clk, rst (async active-low), host (slave handshake), encoder_i_o,
// enable_encoder_o, decoder_i, frames_o, err_total_o.
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int TAIL_LEN  = DEF_TAIL_LEN,
    parameter int DEC_LAT   = DEF_DEC_LAT,
    parameter int STAT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    viterbi_frame_ctrl_if.slave   host,
    output logic                  encoder_i_o,
    output logic                  enable_encoder_o,
    input  logic                  decoder_i,
    output logic [STAT_W-1:0]     frames_o,
    output logic [STAT_W-1:0]     err_total_o
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int CYC_W = $clog2(DEC_LAT + FRAME_LEN + TAIL_LEN + 1);

    localparam logic [CYC_W-1:0] SEND_END = CYC_W'(FRAME_LEN - 1);
    localparam logic [CYC_W-1:0] TAIL_END = CYC_W'(FRAME_LEN + TAIL_LEN - 1);
    localparam logic [CYC_W-1:0] CAP_LO   = CYC_W'(DEC_LAT);
    localparam logic [CYC_W-1:0] CAP_HI   = CYC_W'(DEC_LAT + FRAME_LEN - 1);

    ctrl_state_t          state;
    ctrl_state_t          state_nx;
    logic [FRAME_LEN-1:0] tx_sr;
    logic [FRAME_LEN-1:0] sent_word;
    logic [FRAME_LEN-1:0] rx_sr;
    logic [FRAME_LEN-1:0] rx_word;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W-1:0]     err_nx;
    logic [CYC_W-1:0]     cyc;
    logic                 done_q;
    logic                 busy;
    logic                 accept;
    logic                 cap_en;

    assign busy   = (state == SEND) || (state == TAIL) || (state == DRAIN);
    // done_o is registered, so idle only counts as ready once it drops.
    assign host.ready_o = (state == IDLE) && !done_q;
    assign accept = host.ready_o && host.start_i;
    assign cap_en = busy && (cyc >= CAP_LO) && (cyc <= CAP_HI);
    assign err_nx = CNT_W'(popcount(32'(rx_sr ^ sent_word)));

    assign enable_encoder_o = (state == SEND) || (state == TAIL);
    assign encoder_i_o      = (state == SEND) && tx_sr[FRAME_LEN-1];

    assign host.done_o    = done_q;
    assign host.rx_word_o = rx_word;
    assign host.err_cnt_o = err_cnt;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = SEND;
            SEND:    if (cyc == SEND_END) state_nx = TAIL;
            TAIL: begin
                // Short decoder latency may finish capture inside the tail.
                if (cyc == TAIL_END) state_nx = (cyc >= CAP_HI) ? DONE : DRAIN;
            end
            DRAIN:   if (cyc >= CAP_HI) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (busy && host.abort_i) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_sr     <= '0;
            sent_word <= '0;
            rx_sr     <= '0;
            cyc       <= '0;
            done_q    <= 1'b0;
            rx_word   <= '0;
            err_cnt   <= '0;
        end else begin
            state  <= state_nx;
            done_q <= (state == DONE);
            if (accept) begin
                tx_sr     <= host.frame_i;
                sent_word <= host.frame_i;
                cyc       <= '0;
            end else if (busy) begin
                cyc <= cyc + 1'b1;
                if (state == SEND) tx_sr <= tx_sr << 1;
            end
            if (cap_en) rx_sr <= {rx_sr[FRAME_LEN-2:0], decoder_i};
            if (state == DONE) begin
                rx_word <= rx_sr;
                err_cnt <= err_nx;
            end
        end
    end

    viterbi_stat_counter #(
        .STAT_W (STAT_W),
        .ADD_W  (CNT_W)
    ) u_stat (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (state == DONE),
        .add_i       (err_nx),
        .frames_o    (frames_o),
        .err_total_o (err_total_o)
    );

endmodule
